// File: rtl/stream_gen_pkg.sv
// Shared types and helpers for the AXI-Stream stimulus source and its FIFO.
package stream_gen_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Width helper that never returns zero, so one-entry or one-channel builds still get a 1-bit field.
  function automatic int clog2_guard(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through byte FIFO: head word is visible the cycle after it is written.
module sync_fifo_fwft
  import stream_gen_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = clog2_guard(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o
);

  localparam int AW = clog2_guard(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;
  logic              wr_s, rd_s;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == {CNT_W{1'b0}});
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign dout_o     = mem_q[rd_ptr_q];

  // A push while full is dropped even if a pop frees a slot in the same cycle.
  assign wr_s = push_i && !full_o;
  assign rd_s = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push_i && full_o;
      if (wr_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_s) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_s, rd_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/stream_gen_router.sv
// AXI-Stream stimulus source: frames FIFO bytes into fixed-length packets and routes
// each packet to one of N_CH output channels, locking the destination per packet.
module stream_gen_router
  import stream_gen_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int N_CH   = 5,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = clog2_guard(DEPTH + 1),
  parameter int SEL_W  = clog2_guard(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      din,
  input  logic                   push,
  output logic                   full,
  output logic                   empty,
  output logic [CNT_W-1:0]       buff_count,
  output logic                   overflow,
  input  logic                   op_en,
  input  logic [LEN_W-1:0]       pkt_len,
  input  logic [SEL_W-1:0]       sel,
  output logic [N_CH*DATA_W-1:0] m_tdata,
  output logic [N_CH-1:0]        m_tvalid,
  output logic [N_CH-1:0]        m_tlast,
  input  logic [N_CH-1:0]        m_tready,
  output logic [SEL_W-1:0]       active_ch,
  output logic                   busy,
  output logic                   pkt_done,
  output logic                   sel_err
);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  act_q, act_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic              done_q, done_d;
  logic              serr_q, serr_d;
  logic [DATA_W-1:0] head_s;
  logic              rdy_s, hs_s, last_s;
  logic [N_CH-1:0]   ch_on_s;

  sync_fifo_fwft #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (rst),
    .push_i     (push),
    .pop_i      (hs_s),
    .din_i      (din),
    .dout_o     (head_s),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (buff_count),
    .overflow_o (overflow)
  );

  assign active_ch = act_q;
  assign busy      = (state_q == STREAM);
  assign pkt_done  = done_q;
  assign sel_err   = serr_q;
  assign last_s    = (beat_q == len_q - LEN_W'(1));
  assign hs_s      = busy && !empty && rdy_s;

  // Only the latched channel's ready matters; the others are ignored.
  always_comb begin
    rdy_s = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      rdy_s = rdy_s | (m_tready[c] & (act_q == SEL_W'(c)));
    end
  end

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    len_d   = len_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    serr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_en && !empty) begin
          if (32'(sel) < N_CH) begin
            act_d   = sel;
            len_d   = (pkt_len == {LEN_W{1'b0}}) ? LEN_W'(1) : pkt_len;
            beat_d  = {LEN_W{1'b0}};
            state_d = STREAM;
          end else begin
            serr_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (hs_s) begin
          beat_d = beat_q + LEN_W'(1);
          if (last_s) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = STREAM;
          end
        end else begin
          state_d = STREAM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state and FIFO occupancy, never on m_tready.
  always_comb begin
    m_tvalid = {N_CH{1'b0}};
    m_tlast  = {N_CH{1'b0}};
    m_tdata  = {(N_CH*DATA_W){1'b0}};
    for (int c = 0; c < N_CH; c++) begin
      ch_on_s[c]                  = busy && (act_q == SEL_W'(c));
      m_tvalid[c]                 = ch_on_s[c] && !empty;
      m_tlast[c]                  = ch_on_s[c] && last_s;
      m_tdata[c*DATA_W +: DATA_W] = ch_on_s[c] ? head_s : {DATA_W{1'b0}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      act_q   <= {SEL_W{1'b0}};
      len_q   <= {LEN_W{1'b0}};
      beat_q  <= {LEN_W{1'b0}};
      done_q  <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
      serr_q  <= serr_d;
    end
  end

endmodule

// File: tb/tb_stream_gen_router.sv
// Self-checking bench for stream_gen_router: directed table, test-plan sequences and
// randomized traffic compared against a queue-based packet model.
module tb_stream_gen_router;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int N_CH   = 5;
  localparam int LEN_W  = 8;
  localparam int CNT_W  = 5;
  localparam int SEL_W  = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [DATA_W-1:0]      din;
  logic                   push;
  logic                   full, empty, overflow;
  logic [CNT_W-1:0]       buff_count;
  logic                   op_en;
  logic [LEN_W-1:0]       pkt_len;
  logic [SEL_W-1:0]       sel;
  logic [N_CH*DATA_W-1:0] m_tdata;
  logic [N_CH-1:0]        m_tvalid, m_tlast, m_tready;
  logic [SEL_W-1:0]       active_ch;
  logic                   busy, pkt_done, sel_err;

  always #5 clk = ~clk;

  stream_gen_router dut (
    .clk(clk), .rst(rst), .din(din), .push(push), .full(full), .empty(empty),
    .buff_count(buff_count), .overflow(overflow), .op_en(op_en), .pkt_len(pkt_len),
    .sel(sel), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .active_ch(active_ch), .busy(busy), .pkt_done(pkt_done),
    .sel_err(sel_err)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: byte queue plus the current packet's destination, length and beats sent.
  byte unsigned fq[$];
  bit           m_stream;
  int           m_dest, m_len, m_beats;
  bit           m_ovf, m_serr, m_done;

  // Observed DUT activity for the test-plan specific checks.
  int           hs_count, done_pulses, ovf_pulses;
  byte unsigned last_q[$];

  task automatic model_reset();
    fq.delete();
    m_stream = 1'b0; m_dest = 0; m_len = 1; m_beats = 0;
    m_ovf = 1'b0; m_serr = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_edge();
    bit room, hs;
    room   = (fq.size() < DEPTH);
    m_ovf  = push && !room;
    m_serr = 1'b0;
    m_done = 1'b0;
    hs     = m_stream && (fq.size() > 0) && m_tready[m_dest];
    if (!m_stream) begin
      if (op_en && fq.size() > 0) begin
        if (int'(sel) < N_CH) begin
          m_stream = 1'b1;
          m_dest   = int'(sel);
          m_len    = (pkt_len == 8'd0) ? 1 : int'(pkt_len);
          m_beats  = 0;
        end else begin
          m_serr = 1'b1;
        end
      end
    end else if (hs) begin
      void'(fq.pop_front());
      m_beats++;
      if (m_beats == m_len) begin
        m_done   = 1'b1;
        m_stream = 1'b0;
      end
    end
    if (push && room) fq.push_back(din);
  endtask

  task automatic check_outputs();
    logic [N_CH-1:0]        ev, el;
    logic [N_CH*DATA_W-1:0] ed, mask;
    ev = '0; el = '0; ed = '0; mask = '1;
    if (m_stream) begin
      ev[m_dest] = (fq.size() > 0);
      el[m_dest] = (m_beats == m_len - 1);
      if (fq.size() > 0) ed[m_dest*DATA_W +: DATA_W] = fq[0];
      else mask[m_dest*DATA_W +: DATA_W] = '0;
    end
    chk("tvalid", m_tvalid, ev);
    chk("tlast", m_tlast, el);
    chk("tdata", m_tdata & mask, ed);
    chk("buff_count", buff_count, fq.size());
    chk("full_empty_busy", {full, empty, busy}, {fq.size() == DEPTH, fq.size() == 0, m_stream});
    chk("ovf_selerr_done", {overflow, sel_err, pkt_done}, {m_ovf, m_serr, m_done});
    chk("active_ch", active_ch, m_dest);
    hs_count    += $countones(m_tvalid & m_tready);
    done_pulses += int'(pkt_done);
    ovf_pulses  += int'(overflow);
    for (int c = 0; c < N_CH; c++)
      if (m_tvalid[c] && m_tready[c] && m_tlast[c]) last_q.push_back(m_tdata[c*DATA_W +: DATA_W]);
  endtask

  task automatic tick();
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    push = 1'b0; din = '0; op_en = 1'b0; sel = '0; pkt_len = 8'd1; m_tready = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    hs_count = 0; done_pulses = 0; ovf_pulses = 0;
    last_q.delete();
  endtask

  task automatic push_bytes(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      push = 1'b1;
      din  = 8'(base + i);
      tick();
    end
    push = 1'b0;
  endtask

  typedef struct {
    logic             push;
    logic [7:0]       din;
    logic             op_en;
    logic [2:0]       sel;
    logic [7:0]       len;
    logic [4:0]       rdy;
    int               cnt;
    logic             busy;
    logic [2:0]       ach;
    logic [4:0]       tv;
    logic [4:0]       tl;
    logic [7:0]       td;
    logic [2:0]       pulses;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // push din op sel len rdy | cnt busy ach tvalid tlast tdata {ovf,serr,done}
    tbl[0] = '{1'b1, 8'hA0, 1'b0, 3'd0, 8'd1, 5'b00000, 1, 1'b0, 3'd0, 5'b00000, 5'b00000, 8'h00, 3'b000};
    tbl[1] = '{1'b1, 8'hA1, 1'b0, 3'd0, 8'd1, 5'b00000, 2, 1'b0, 3'd0, 5'b00000, 5'b00000, 8'h00, 3'b000};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 3'd5, 8'd1, 5'b00000, 2, 1'b0, 3'd0, 5'b00000, 5'b00000, 8'h00, 3'b010};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 3'd3, 8'd0, 5'b00000, 2, 1'b1, 3'd3, 5'b01000, 5'b01000, 8'hA0, 3'b000};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 3'd0, 8'd1, 5'b01000, 1, 1'b0, 3'd3, 5'b00000, 5'b00000, 8'h00, 3'b001};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 3'd0, 8'd2, 5'b00000, 1, 1'b1, 3'd0, 5'b00001, 5'b00000, 8'hA1, 3'b000};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 3'd0, 8'd2, 5'b00001, 0, 1'b1, 3'd0, 5'b00000, 5'b00001, 8'h00, 3'b000};
    tbl[7] = '{1'b1, 8'hA2, 1'b0, 3'd0, 8'd2, 5'b00001, 1, 1'b1, 3'd0, 5'b00001, 5'b00001, 8'hA2, 3'b000};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 3'd0, 8'd2, 5'b00001, 0, 1'b0, 3'd0, 5'b00000, 5'b00000, 8'h00, 3'b001};

    do_reset();
    chk("reset_flags", {empty, full, busy, overflow, pkt_done, sel_err}, 6'b100000);
    chk("reset_outputs", {m_tvalid, m_tlast, buff_count, active_ch}, '0);

    for (int i = 0; i < 9; i++) begin
      push = tbl[i].push; din = tbl[i].din; op_en = tbl[i].op_en;
      sel = tbl[i].sel; pkt_len = tbl[i].len; m_tready = tbl[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_count", i), buff_count, tbl[i].cnt);
      chk($sformatf("tbl%0d_busy_ach", i), {busy, active_ch}, {tbl[i].busy, tbl[i].ach});
      chk($sformatf("tbl%0d_tvalid_tlast", i), {m_tvalid, m_tlast}, {tbl[i].tv, tbl[i].tl});
      chk($sformatf("tbl%0d_pulses", i), {overflow, sel_err, pkt_done}, tbl[i].pulses);
      if (tbl[i].tv != 5'b0)
        chk($sformatf("tbl%0d_tdata", i), 8'(m_tdata >> (int'(tbl[i].ach) * DATA_W)), tbl[i].td);
    end

    // Four 4-beat packets on ch2 from a full FIFO.
    do_reset();
    push_bytes(16, 0);
    op_en = 1'b1; sel = 3'd2; pkt_len = 8'd4; m_tready = '1;
    repeat (30) tick();
    chk("seq1_done_pulses", done_pulses, 4);
    chk("seq1_last_count", last_q.size(), 4);
    if (last_q.size() == 4)
      for (int k = 0; k < 4; k++) chk("seq1_last_byte", last_q[k], 4 * k + 3);

    // Overflow: 17th byte dropped and never emitted.
    do_reset();
    push_bytes(17, 8'h20);
    tick();
    chk("seq2_ovf_pulses", ovf_pulses, 1);
    chk("seq2_full", {full, buff_count}, {1'b1, 5'd16});
    op_en = 1'b1; sel = 3'd0; pkt_len = 8'd16; m_tready = '1;
    repeat (20) tick();
    chk("seq2_last_byte", (last_q.size() > 0) ? last_q[$] : 8'h00, 8'h2F);

    // Destination stays locked mid-packet; new sel applies to the next packet.
    do_reset();
    push_bytes(6, 8'h40);
    op_en = 1'b1; sel = 3'd1; pkt_len = 8'd3; m_tready = '1;
    tick();
    tick();
    sel = 3'd4;
    tick();
    tick();
    chk("seq3_ach_locked", active_ch, 3'd1);
    tick();
    chk("seq3_ach_next", active_ch, 3'd4);
    repeat (5) tick();

    // Back-pressure on ch0 with ready pattern 1,0,0,1.
    do_reset();
    push_bytes(5, 8'h60);
    op_en = 1'b1; sel = 3'd0; pkt_len = 8'd5;
    for (int k = 0; k < 20; k++) begin
      m_tready = {4'b0, ((k % 4) == 0) || ((k % 4) == 3)};
      tick();
    end
    chk("seq4_handshakes", hs_count, 5);
    chk("seq4_last_byte", (last_q.size() == 1) ? last_q[0] : 8'h00, 8'h64);

    // Underrun bubble mid-packet on ch3.
    do_reset();
    push_bytes(2, 8'h80);
    op_en = 1'b1; sel = 3'd3; pkt_len = 8'd4; m_tready = '1;
    repeat (4) tick();
    chk("seq5_bubble", {busy, m_tvalid}, {1'b1, 5'b00000});
    op_en = 1'b0;
    push_bytes(2, 8'h82);
    repeat (4) tick();
    chk("seq5_last_byte", (last_q.size() == 1) ? last_q[0] : 8'h00, 8'h83);

    // Invalid sel, then async reset in the middle of a packet.
    do_reset();
    push_bytes(1, 8'h90);
    op_en = 1'b1; sel = 3'd5; pkt_len = 8'd8;
    repeat (2) tick();
    sel = 3'd1; m_tready = '1;
    push_bytes(6, 8'h91);
    #2;
    rst = 1'b0;
    #1;
    chk("seq6_async_rst", {m_tvalid, empty, busy, buff_count}, {5'b0, 1'b1, 1'b0, 5'd0});
    model_reset();
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) tick();

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      push     = ($urandom_range(0, 99) < 55);
      din      = 8'($urandom);
      op_en    = ($urandom_range(0, 3) != 0);
      sel      = 3'($urandom_range(0, 7));
      pkt_len  = 8'($urandom_range(0, 6));
      m_tready = 5'($urandom);
      if ($urandom_range(0, 999) == 0) do_reset();
      else tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/stream_gen_router.md
Name: stream_gen_router

Overview:
Parametrised AXI-Stream stimulus source for the I2C multi-node bench: a first-word-fall-through byte FIFO feeding a 1-to-N_CH packet router.
- Frames FIFO contents into packets of programmable length, generating tlast itself.
- Routes each packet to one selected downstream s_axis_data port (masters/slaves).
- Destination is locked per packet; changes to sel take effect only at packet boundaries.

Parameters:
DATA_W, 8, data width of din / tdata
DEPTH, 16, FIFO entries; power of two, >= 2
N_CH, 5, number of output channels
LEN_W, 8, width of pkt_len
CNT_W, $clog2(DEPTH+1), width of buff_count (derived, do not override)
SEL_W, (N_CH>1 ? $clog2(N_CH) : 1), width of sel/active_ch (derived)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
din  in  DATA_W  write data
push  in  1  write strobe; ignored when full
full  out  1  buff_count == DEPTH
empty  out  1  buff_count == 0
buff_count  out  CNT_W  current occupancy
overflow  out  1  one-cycle pulse: push while full (data dropped)
op_en  in  1  permit start of a new packet
pkt_len  in  LEN_W  beats per packet; 0 treated as 1
sel  in  SEL_W  destination channel for next packet
m_tdata  out  N_CH*DATA_W  channel c at [c*DATA_W +: DATA_W]
m_tvalid  out  N_CH  per-channel valid
m_tlast  out  N_CH  per-channel last
m_tready  in  N_CH  per-channel ready
active_ch  out  SEL_W  latched destination of current/last packet
busy  out  1  high in STREAM
pkt_done  out  1  one-cycle pulse on final-beat handshake
sel_err  out  1  one-cycle pulse: start attempted with sel >= N_CH

Behaviour:
- Reset (rst low, async): pointers, count, beat counter, and FSM cleared. Outputs at reset: empty=1, all others 0; state IDLE.
- FIFO:
  - Registered storage, FWFT. Head word is valid the cycle after it is written.
  - push && !full: write at wr_ptr, wr_ptr wraps mod DEPTH.
  - push && full: rejected, overflow pulses. This holds even if a pop occurs in the same cycle.
  - pop = handshake on active channel. Same-cycle push+pop leaves buff_count unchanged; otherwise count changes by +/-1.
- FSM, states IDLE and STREAM:
  - IDLE, op_en && !empty && sel < N_CH: latch active_ch <= sel, len_q <= max(pkt_len,1), beat_cnt <= 0, go STREAM.
  - IDLE, op_en && !empty && sel >= N_CH: pulse sel_err, stay IDLE, consume nothing.
  - STREAM outputs:
    - m_tvalid[active_ch] = !empty.
    - m_tdata[active_ch] = FIFO head.
    - m_tlast[active_ch] = (beat_cnt == len_q-1).
  - STREAM, each handshake (tvalid && tready on active_ch): pop, beat_cnt++.
  - STREAM, handshake with tlast: pulse pkt_done (registered, next cycle), return to IDLE.
  - FIFO empty mid-packet: tvalid drops (bubble). Stay in STREAM; beat_cnt holds.
  - op_en, sel, and pkt_len are sampled only in IDLE. Deasserting op_en mid-packet does not truncate the packet.
- Non-active channels drive tvalid=0, tlast=0, tdata=0. Their tready is ignored.
- No combinational path from m_tready to any m_tvalid.
- Back-to-back packets: one IDLE cycle between the last beat of packet k and the first beat of packet k+1.
- Latency: push at cycle n, FSM in IDLE with op_en=1 -> first tvalid at cycle n+2.
- beat_cnt is LEN_W bits; len_q up to 2^LEN_W-1.

Decomposition:
- Package stream_gen_pkg holds: the state enum typedef (IDLE, STREAM) and a localparam function for the SEL_W/CNT_W clog2 guard.
- One sub-module, sync_fifo_fwft (DATA_W, DEPTH). It provides push/pop/full/empty/count.
- The router FSM and per-channel output muxing stay in the top module.

Test Plan:
- Fill 16 bytes 0x00..0x0F, sel=2, pkt_len=4, all tready=1, op_en=1 -> four packets on ch2. tlast on bytes 0x03/0x07/0x0B/0x0F; 4 pkt_done pulses; other channels' tvalid never high.
- Push 17 bytes with op_en=0 -> full=1, buff_count=16, overflow pulses once; byte 17 never appears on any output.
- pkt_len=3, sel=1; after the first handshake change sel=4 -> remaining 2 beats still on ch1, active_ch=1. The next packet goes to ch4.
- ch0 tready toggles 1,0,0,1..., pkt_len=5, 5 bytes queued -> tdata/tlast held stable while stalled; exactly 5 handshakes; tlast on the 5th.
- Push 2 bytes, pkt_len=4, ch3 ready -> 2 beats, then tvalid=0 with busy=1. Push 2 more -> beats resume and tlast falls on beat 4.
- sel=5 with N_CH=5 -> sel_err pulse, buff_count unchanged. Assert rst mid-packet -> all tvalid=0 and empty=1 immediately (async), state IDLE.
